// File: rtl/fp_normalize_round.sv
// fp_normalize_round: post-add stage of the FP32 adder.
// Takes the raw aligned-mantissa sum and renormalizes it, one bit per cycle.
// Then rounds to nearest-even and packs an IEEE-754 single result.
//
// Handshake: an input transfers on the rising edge where in_valid & in_ready.
// in_ready is high only in IDLE, so the block holds at most one operation.
// The result transfers on the rising edge where out_valid & out_ready.
// While out_valid & !out_ready, result_out and the flags hold steady.
module fp_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int EXT_W  = 8,
  localparam int MW    = FRAC_W + EXT_W + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exponent_in,
  input  logic [MW-1:0]     sum_mantissa_in,
  input  logic              sticky_in,
  input  logic              bypass_in,
  input  logic [31:0]       bypass_result_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result_out,
  output logic              overflow_out,
  output logic              underflow_out,
  output logic              inexact_out,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LSHIFT = 3'd1,
    S_RSHIFT = 3'd2,
    S_ROUND  = 3'd3,
    S_PACK   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_TWO = EXP_W'(2);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  state_t             state;
  logic [MW-1:0]      m;
  logic [EXP_W-1:0]   e;
  logic               s;
  logic               stk;
  logic               rc;    // a round-carry renormalization already happened
  logic               inx;   // inexact captured at round time

  // An exponent of 0 denotes a subnormal operand, which lives at exponent 1.
  logic [EXP_W-1:0]   exp_eff;
  logic [EXP_W-1:0]   e_inc;
  logic               g;
  logic               st;
  logic               lsb;
  logic               up;
  logic [MW-EXT_W-1:0] rnd_hi;
  logic [EXP_W-1:0]   exp_field;

  assign exp_eff   = (exponent_in == '0) ? EXP_ONE : exponent_in;
  assign e_inc     = e + EXP_ONE;
  assign g         = m[EXT_W-1];
  assign st        = (|m[EXT_W-2:0]) | stk;
  assign lsb       = m[EXT_W];
  assign up        = g & (st | lsb);
  assign rnd_hi    = m[MW-1:EXT_W] + {{(MW-EXT_W-1){1'b0}}, up};
  assign exp_field = m[MW-2] ? e : '0;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign state_dbg = state;

  // Normalize/round/pack state machine; result and flags are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      m             <= '0;
      e             <= '0;
      s             <= 1'b0;
      stk           <= 1'b0;
      rc            <= 1'b0;
      inx           <= 1'b0;
      result_out    <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      inexact_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            m             <= sum_mantissa_in;
            e             <= exp_eff;
            s             <= sign_in;
            stk           <= sticky_in;
            rc            <= 1'b0;
            inx           <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
            inexact_out   <= 1'b0;
            if (bypass_in) begin
              result_out <= bypass_result_in;
              state      <= S_DONE;
            end else if (sum_mantissa_in == '0) begin
              result_out <= {sign_in, 31'b0};
              state      <= S_DONE;
            end else if (sum_mantissa_in[MW-1]) begin
              state <= S_RSHIFT;
            end else if (sum_mantissa_in[MW-2] || exp_eff == EXP_ONE) begin
              // Already normalized, or already at the subnormal floor.
              state <= S_ROUND;
            end else begin
              state <= S_LSHIFT;
            end
          end
        end
        S_LSHIFT: begin
          // Entry guarantees m[MW-2]==0 and e>1, so every cycle here shifts;
          // leave as soon as the shifted value is normalized or e reaches 1.
          m <= m << 1;
          e <= e - EXP_ONE;
          if (m[MW-3] || e == EXP_TWO) state <= S_ROUND;
        end
        S_RSHIFT: begin
          stk <= stk | m[0];
          m   <= m >> 1;
          e   <= e_inc;
          if (e_inc == EXP_MAX) begin
            result_out   <= {s, EXP_MAX, {FRAC_W{1'b0}}};
            overflow_out <= 1'b1;
            inexact_out  <= 1'b1;
            state        <= S_DONE;
          end else if (rc) begin
            state <= S_PACK;
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          m   <= {rnd_hi, m[EXT_W-1:0]};
          inx <= g | st;
          if (rnd_hi[MW-EXT_W-1]) begin
            rc    <= 1'b1;
            state <= S_RSHIFT;
          end else begin
            state <= S_PACK;
          end
        end
        S_PACK: begin
          result_out    <= {s, exp_field, m[MW-3:EXT_W]};
          underflow_out <= (exp_field == '0);
          inexact_out   <= inx;
          state         <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: directed and randomized vectors for fp_normalize_round.
module tb_fp_normalize_round;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exponent_in;
  logic [32:0] sum_mantissa_in;
  logic        sticky_in;
  logic        bypass_in;
  logic [31:0] bypass_result_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_out;
  logic        overflow_out;
  logic        underflow_out;
  logic        inexact_out;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit seen  = 0;

  // expected {result, overflow, underflow, inexact}
  logic [34:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  fp_normalize_round dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .sign_in          (sign_in),
    .exponent_in      (exponent_in),
    .sum_mantissa_in  (sum_mantissa_in),
    .sticky_in        (sticky_in),
    .bypass_in        (bypass_in),
    .bypass_result_in (bypass_result_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result_out       (result_out),
    .overflow_out     (overflow_out),
    .underflow_out    (underflow_out),
    .inexact_out      (inexact_out),
    .state_dbg        (state_dbg)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [34:0] mk(input logic [31:0] r, input logic o, input logic u, input logic i);
    return {r, o, u, i};
  endfunction

  // Drive one operation; when track is set, queue its expected result and latency.
  task automatic send(input logic sg, input logic [7:0] ex, input logic [32:0] sm,
                      input logic sk, input logic byp, input logic [31:0] br,
                      input logic [34:0] expv, input int lat, input bit track);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
      return;
    end
    sign_in          = sg;
    exponent_in      = ex;
    sum_mantissa_in  = sm;
    sticky_in        = sk;
    bypass_in        = byp;
    bypass_result_in = br;
    in_valid         = 1'b1;
    if (track) begin
      exp_q.push_back(expv);
      lat_q.push_back(lat);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    bypass_in = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || out_valid) && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (b >= 300) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: compare the first cycle of each out_valid against the queue head
  always @(negedge clk) begin
    logic [34:0] ev;
    int l;
    int a;
    if (!reset_n) begin
      seen = 0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {63'b0, out_valid}, 64'd0);
        end else begin
          ev = exp_q.pop_front();
          l  = lat_q.pop_front();
          a  = acc_q.pop_front();
          check("result",    64'(result_out),    64'(ev[34:3]));
          check("overflow",  64'(overflow_out),  64'(ev[2]));
          check("underflow", 64'(underflow_out), 64'(ev[1]));
          check("inexact",   64'(inexact_out),   64'(ev[0]));
          check("latency",   64'(cyc - a + 1),   64'(l));
        end
      end
      if (out_valid && out_ready) seen = 0;
    end
  end

  // watchdog
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic sg;
    logic [32:0] sm;
    int b;

    reset_n          = 1'b0;
    in_valid         = 1'b0;
    out_ready        = 1'b1;
    sign_in          = 1'b0;
    exponent_in      = '0;
    sum_mantissa_in  = '0;
    sticky_in        = 1'b0;
    bypass_in        = 1'b0;
    bypass_result_in = '0;
    #1;
    check("rst_in_ready",  64'(in_ready),      64'd1);
    check("rst_out_valid", 64'(out_valid),     64'd0);
    check("rst_result",    64'(result_out),    64'd0);
    check("rst_flags",     64'({overflow_out, underflow_out, inexact_out}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // carry out of the adder
    send(0, 8'h7F, 33'h1_8000_0000, 0, 0, 0, mk(32'h40400000, 0, 0, 0), 4, 1);
    // heavy cancellation
    send(0, 8'h7F, 33'h0_0000_0100, 0, 0, 0, mk(32'h34000000, 0, 0, 0), 26, 1);
    // round to nearest even
    send(0, 8'h7F, 33'h0_8000_0180, 0, 0, 0, mk(32'h3F800002, 0, 0, 1), 3, 1);
    send(0, 8'h7F, 33'h0_8000_0080, 0, 0, 0, mk(32'h3F800000, 0, 0, 1), 3, 1);
    send(0, 8'h7F, 33'h0_8000_0080, 1, 0, 0, mk(32'h3F800001, 0, 0, 1), 3, 1);
    // rounding carry and overflow
    send(0, 8'h7F, 33'h0_FFFF_FF80, 1, 0, 0, mk(32'h40000000, 0, 0, 1), 4, 1);
    send(0, 8'hFE, 33'h1_0000_0000, 0, 0, 0, mk(32'h7F800000, 1, 0, 1), 2, 1);
    // subnormal, signed zero, bypass
    send(0, 8'h02, 33'h0_2000_0000, 0, 0, 0, mk(32'h00400000, 0, 1, 0), 4, 1);
    send(1, 8'h7F, 33'h0,           0, 0, 0, mk(32'h80000000, 0, 0, 0), 1, 1);
    send(0, 8'h10, 33'h0_1234_5678, 0, 1, 32'h7FC00000, mk(32'h7FC00000, 0, 0, 0), 1, 1);
    drain();

    // exact powers of two: value 2^-k normalizes in k shifts
    for (int i = 0; i < 8; i++) begin
      k  = $urandom_range(0, 30);
      sg = 1'($urandom_range(0, 1));
      sm = 33'd1 << (31 - k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(sg, 8'h7F, sm, 0, 0, 0, mk({sg, 8'(127 - k), 23'b0}, 0, 0, 0), 3 + k, 1);
    end
    drain();

    // backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    send(0, 8'h7F, 33'h1_8000_0000, 0, 0, 0, mk(32'h40400000, 0, 0, 0), 4, 1);
    b = 0;
    while (!out_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result",    64'(result_out), 64'h40400000);
      check("bp_out_valid", 64'(out_valid),  64'd1);
      check("bp_in_ready",  64'(in_ready),   64'd0);
    end
    out_ready = 1'b1;
    drain();

    // reset in the middle of a long left shift
    send(0, 8'h7F, 33'h0_0000_0100, 0, 0, 0, '0, 0, 0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send(0, 8'h7F, 33'h0_8000_0180, 0, 0, 0, mk(32'h3F800002, 0, 0, 1), 3, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
